// File: rtl/tmds_decode_align.sv
// TMDS channel receiver: bit-slip symbol alignment on control-token runs, then 10b->8b decode.
// Latency: 2 cycles from the clock edge that samples raw_word to dout/c0/c1/de.
// Backpressure: none; free-running stream, one word in and one decoded symbol out per clock.
//
// Ports:
//   clkin     in   1   pixel clock
//   rstin     in   1   synchronous reset, active high
//   raw_word  in  10   deserialized word, bit 0 earliest on the wire
//   dout      out  8   decoded pixel data (0 on control tokens and while unlocked)
//   c0, c1    out  1   decoded control bits (hold across data symbols)
//   de        out  1   1 = data symbol, 0 = control token
//   locked    out  1   symbol alignment achieved
//   slip_cnt  out  4   current bit offset into the 20-bit window, 0..9
module tmds_decode_align #(
    parameter int TOKEN_RUN = 8,
    parameter int TIMEOUT   = 4096,
    parameter int SETTLE    = 3
) (
    input  logic       clkin,
    input  logic       rstin,
    input  logic [9:0] raw_word,
    output logic [7:0] dout,
    output logic       c0,
    output logic       c1,
    output logic       de,
    output logic       locked,
    output logic [3:0] slip_cnt
);

    localparam int TW = (TIMEOUT > 2)   ? $clog2(TIMEOUT)     : 1;
    localparam int RW = $clog2(TOKEN_RUN + 1);
    localparam int SW = (SETTLE > 1)    ? $clog2(SETTLE + 1)  : 1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Registers
    state_t          r_state;
    logic [9:0]      r_prev;
    logic [9:0]      r_sym;
    logic [RW-1:0]   r_run;
    logic [TW-1:0]   r_timer;
    logic [SW-1:0]   r_settle;
    logic [3:0]      r_slip;
    logic [7:0]      r_dout;
    logic            r_c0;
    logic            r_c1;
    logic            r_de;

    // Combinational signals
    logic [19:0]     w_window;
    logic [9:0]      w_sym_sel;
    logic            w_tok;
    logic [1:0]      w_tok_c;      // {c1, c0}
    logic [7:0]      w_d;
    logic [7:0]      w_data;
    logic [3:0]      w_slip_inc;
    state_t          w_state_nxt;
    logic [RW-1:0]   w_run_nxt;
    logic [TW-1:0]   w_timer_nxt;
    logic [SW-1:0]   w_settle_nxt;
    logic [3:0]      w_slip_nxt;
    logic            w_lock_nxt;

    // Older word sits in the low half so that bit order matches wire order.
    assign w_window = {raw_word, r_prev};

    // Explicit mux keeps the select inside the 20-bit window for every slip value.
    always_comb begin
        w_sym_sel = w_window[9:0];
        case (r_slip)
            4'd0:    w_sym_sel = w_window[9:0];
            4'd1:    w_sym_sel = w_window[10:1];
            4'd2:    w_sym_sel = w_window[11:2];
            4'd3:    w_sym_sel = w_window[12:3];
            4'd4:    w_sym_sel = w_window[13:4];
            4'd5:    w_sym_sel = w_window[14:5];
            4'd6:    w_sym_sel = w_window[15:6];
            4'd7:    w_sym_sel = w_window[16:7];
            4'd8:    w_sym_sel = w_window[17:8];
            4'd9:    w_sym_sel = w_window[18:9];
            default: w_sym_sel = w_window[9:0];
        endcase
    end

    // Control token match on the aligned symbol
    always_comb begin
        w_tok   = 1'b0;
        w_tok_c = 2'b00;
        case (r_sym)
            10'b1101010100: begin w_tok = 1'b1; w_tok_c = 2'b00; end
            10'b0010101011: begin w_tok = 1'b1; w_tok_c = 2'b01; end
            10'b0101010100: begin w_tok = 1'b1; w_tok_c = 2'b10; end
            10'b1010101011: begin w_tok = 1'b1; w_tok_c = 2'b11; end
            default:        begin w_tok = 1'b0; w_tok_c = 2'b00; end
        endcase
    end

    // Data decode: undo optional inversion (bit 9), then undo XOR/XNOR chain (bit 8).
    always_comb begin
        w_data    = 8'h00;
        w_d       = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
        w_data[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            w_data[i] = r_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    assign w_slip_inc = (r_slip == 4'd9) ? 4'd0 : r_slip + 4'd1;

    // Alignment FSM: next state and counters
    always_comb begin
        w_state_nxt  = r_state;
        w_run_nxt    = r_run;
        w_timer_nxt  = r_timer;
        w_settle_nxt = r_settle;
        w_slip_nxt   = r_slip;
        case (r_state)
            ST_SEARCH: begin
                w_timer_nxt = r_timer + 1'b1;
                if (w_tok) begin
                    w_run_nxt = (r_run == RW'(TOKEN_RUN)) ? r_run : r_run + 1'b1;
                end else begin
                    w_run_nxt = '0;
                end
                // Lock wins over a coincident timeout.
                if (w_tok && (r_run >= RW'(TOKEN_RUN - 1))) begin
                    w_state_nxt = ST_LOCKED;
                    w_timer_nxt = '0;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_state_nxt  = ST_SLIP;
                    w_slip_nxt   = w_slip_inc;
                    w_run_nxt    = '0;
                    w_timer_nxt  = '0;
                    w_settle_nxt = '0;
                end
            end
            ST_SLIP: begin
                // Tokens are ignored while the window refills at the new offset.
                w_run_nxt    = '0;
                w_timer_nxt  = '0;
                w_settle_nxt = r_settle + 1'b1;
                if (r_settle >= SW'(SETTLE - 1)) begin
                    w_state_nxt  = ST_SEARCH;
                    w_settle_nxt = '0;
                end
            end
            ST_LOCKED: begin
                // A token on the expiry cycle still refreshes the lock.
                if (w_tok) begin
                    w_timer_nxt = '0;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_state_nxt  = ST_SLIP;
                    w_slip_nxt   = w_slip_inc;
                    w_run_nxt    = '0;
                    w_timer_nxt  = '0;
                    w_settle_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt  = ST_SEARCH;
                w_run_nxt    = '0;
                w_timer_nxt  = '0;
                w_settle_nxt = '0;
            end
        endcase
    end

    // Outputs follow the lock state they are presented with, so they are
    // gated on the state being entered rather than the one being left.
    assign w_lock_nxt = (w_state_nxt == ST_LOCKED);

    always_ff @(posedge clkin) begin
        if (rstin) begin
            r_state  <= ST_SEARCH;
            r_prev   <= 10'd0;
            r_sym    <= 10'd0;
            r_run    <= '0;
            r_timer  <= '0;
            r_settle <= '0;
            r_slip   <= 4'd0;
            r_dout   <= 8'h00;
            r_c0     <= 1'b0;
            r_c1     <= 1'b0;
            r_de     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_prev   <= raw_word;
            r_sym    <= w_sym_sel;
            r_run    <= w_run_nxt;
            r_timer  <= w_timer_nxt;
            r_settle <= w_settle_nxt;
            r_slip   <= w_slip_nxt;
            if (!w_lock_nxt) begin
                r_dout <= 8'h00;
                r_de   <= 1'b0;
                r_c0   <= 1'b0;
                r_c1   <= 1'b0;
            end else if (w_tok) begin
                r_dout <= 8'h00;
                r_de   <= 1'b0;
                r_c0   <= w_tok_c[0];
                r_c1   <= w_tok_c[1];
            end else begin
                r_dout <= w_data;
                r_de   <= 1'b1;
            end
        end
    end

    assign dout     = r_dout;
    assign c0       = r_c0;
    assign c1       = r_c1;
    assign de       = r_de;
    assign locked   = (r_state == ST_LOCKED);
    assign slip_cnt = r_slip;

endmodule

// File: tb/tb_tmds_decode_align.sv
// Bench for tmds_decode_align: scoreboard on decoded symbols plus lock/slip sequencing.
// Latency: expected entries are compared three negedges after the word is driven.
// Backpressure: none; stimulus is one word per clock.
module tb_tmds_decode_align;

    logic       clkin = 1'b0;
    logic       rstin = 1'b1;
    logic [9:0] raw_word = 10'd0;
    logic [7:0] dout;
    logic       c0;
    logic       c1;
    logic       de;
    logic       locked;
    logic [3:0] slip_cnt;

    always #5 clkin = ~clkin;

    tmds_decode_align #(
        .TOKEN_RUN (8),
        .TIMEOUT   (64),
        .SETTLE    (3)
    ) dut (
        .clkin    (clkin),
        .rstin    (rstin),
        .raw_word (raw_word),
        .dout     (dout),
        .c0       (c0),
        .c1       (c1),
        .de       (de),
        .locked   (locked),
        .slip_cnt (slip_cnt)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [10:0] sb_q[$];     // {de, c1, c0, dout}
    bit          sb_en    = 1'b0;
    logic [1:0]  last_c   = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {hit, c1, c0}
    function automatic logic [2:0] tok_info(input logic [9:0] s);
        case (s)
            10'h354: return 3'b100;
            10'h0AB: return 3'b101;
            10'h154: return 3'b110;
            10'h2AB: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] o;
        d    = s[9] ? ~s[7:0] : s[7:0];
        o    = 8'h00;
        o[0] = d[0];
        for (int i = 1; i < 8; i++) o[i] = d[i] ^ d[i-1] ^ ~s[8];
        return o;
    endfunction

    task automatic push_exp(input logic [9:0] s);
        logic [2:0] info;
        info = tok_info(s);
        if (info[2]) begin
            last_c = info[1:0];
            sb_q.push_back({1'b0, info[1:0], 8'h00});
        end else begin
            sb_q.push_back({1'b1, last_c, dec(s)});
        end
    endtask

    // Drive one word; retire the scoreboard entry whose output is now visible.
    task automatic step(input logic [9:0] w);
        logic [10:0] e;
        @(negedge clkin);
        if (sb_q.size() >= 3) begin
            e = sb_q.pop_front();
            check("decode", {21'd0, de, c1, c0, dout}, {21'd0, e});
        end
        raw_word = w;
        if (sb_en) push_exp(w);
    endtask

    task automatic do_reset(input int cyc);
        @(negedge clkin);
        rstin = 1'b1;
        for (int i = 0; i < cyc; i++) begin
            raw_word = 10'($urandom_range(0, 1023));
            @(negedge clkin);
        end
        rstin    = 1'b0;
        raw_word = 10'd0;
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        logic [2:0] info;
        do begin
            w    = 10'($urandom_range(0, 1023));
            info = tok_info(w);
        end while (info[2]);
        return w;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] toks[4];
        logic [9:0] prev_sym;
        logic [9:0] cur;
        logic [3:0] last_slip;
        bit         wrapped;

        toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

        // Reset with random input words
        do_reset(3);
        check("rst_locked", locked, 0);
        check("rst_slip", slip_cnt, 0);
        check("rst_outs", {de, c1, c0, dout}, 0);

        // Aligned lock: lock visible two edges after the 8th token is sampled
        for (int k = 1; k <= 20; k++) begin
            step(10'h354);
            check("lock_time", locked, (k >= 11) ? 1 : 0);
        end
        check("lock_slip", slip_cnt, 0);

        // Decode while locked, through the scoreboard
        sb_en  = 1'b1;
        last_c = 2'b00;
        step(10'h100);
        step(10'h2FF);
        step(10'h0AB);
        step(10'h2FF);
        step(10'h2AB);
        step(10'h100);
        for (int i = 0; i < 32; i++) begin
            if (i % 4 == 3) step(toks[$urandom_range(0, 3)]);
            else            step(rand_data());
        end
        for (int i = 0; i < 3; i++) step(10'h354);
        sb_en = 1'b0;
        sb_q.delete();

        // Loss of lock after a long run of data symbols
        for (int i = 0; i < 60; i++) step(10'h100);
        check("lol_hold", locked, 1);
        for (int i = 0; i < 40 && locked; i++) step(10'h100);
        check("lol_fall", locked, 0);
        check("lol_slip", slip_cnt, 1);
        check("lol_outs", {de, c1, c0, dout}, 0);

        // Offset lock: symbol boundaries at raw bit 3
        do_reset(1);
        prev_sym  = 10'd0;
        last_slip = 4'd0;
        for (int i = 0; i < 600 && !locked; i++) begin
            cur = (i % 12 == 11) ? 10'h100 : 10'h354;
            step({cur[6:0], prev_sym[9:7]});
            prev_sym = cur;
            if (slip_cnt != last_slip) begin
                check("off_slip_step", slip_cnt, last_slip + 4'd1);
                last_slip = slip_cnt;
            end
            if (locked) check("off_no_false_lock", slip_cnt, 3);
        end
        check("off_locked", locked, 1);
        check("off_slip", slip_cnt, 3);
        for (int i = 0; i < 3; i++) begin
            cur = 10'h354;
            step({cur[6:0], prev_sym[9:7]});
            prev_sym = cur;
        end
        check("off_hold", locked, 1);

        // Reset while locked
        do_reset(1);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_slip", slip_cnt, 0);
        check("mid_rst_outs", {de, c1, c0, dout}, 0);

        // Slip counter walks 0..9 and wraps to 0 with no tokens present
        last_slip = 4'd0;
        wrapped   = 1'b0;
        for (int i = 0; i < 1000 && !wrapped; i++) begin
            step(10'd0);
            if (slip_cnt != last_slip) begin
                check("wrap_step", slip_cnt, (last_slip == 4'd9) ? 4'd0 : last_slip + 4'd1);
                if (last_slip == 4'd9 && slip_cnt == 4'd0) wrapped = 1'b1;
                last_slip = slip_cnt;
            end
        end
        check("wrap_seen", wrapped, 1);
        check("wrap_unlocked", locked, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tmds_decode_align.md
Name: tmds_decode_align

Overview:
- Receive-side counterpart of the TMDS channel encoder.
- Takes raw 10-bit words from one channel's deserializer in the pixel clock domain. Word boundaries are arbitrary relative to symbol boundaries.
- Finds symbol alignment by bit-slipping until a run of TMDS control tokens appears.
- Decodes aligned symbols back to 8-bit pixel data, c0/c1 and de. One instance per channel; sits between the deserializer and the video timing recovery logic.

Parameters:
- TOKEN_RUN, 8: consecutive control tokens required to declare lock.
- TIMEOUT, 4096: cycles without lock (SEARCH) or without any control token (LOCKED) before slipping one bit; must exceed one line period.
- SETTLE, 3: cycles ignored after each slip while the pipeline refills.

Ports:
- clkin  in  1  pixel clock.
- rstin  in  1  synchronous reset, active high.
- raw_word  in  10  deserialized word; bit 0 is the earliest received bit.
- dout  out  8  decoded pixel data.
- c0  out  1  decoded control bit 0.
- c1  out  1  decoded control bit 1.
- de  out  1  data enable; 1 = data symbol.
- locked  out  1  alignment achieved.
- slip_cnt  out  4  current bit offset, 0..9.

Behaviour:
- Reset: clkin and rstin are the only clock/reset; rstin is synchronous, active high. On the edge where rstin=1, all of the following clear: dout=0, c0=0, c1=0, de=0, locked=0, slip_cnt=0, state=SEARCH, all counters=0, prev word=0. Reset mid-operation has the same effect.
- Alignment window: window[19:0] = {raw_word, prev_word}, where prev_word is raw_word registered one cycle. Aligned symbol sym = window[slip_cnt +: 10], registered (stage 1).
- Token match on sym, with (c1,c0) given for each:
  - 10'b1101010100 → (0,0)
  - 10'b0010101011 → (0,1)
  - 10'b0101010100 → (1,0)
  - 10'b1010101011 → (1,1)
- Data decode: d = sym[9] ? ~sym[7:0] : sym[7:0]. Then out[0] = d[0]. For i = 1..7: out[i] = sym[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Outputs, registered (stage 2); latency raw_word → outputs = 2 cycles:
  - Token: de=0, c1/c0 per table, dout=0.
  - Non-token: de=1, dout=out, c0/c1 hold their previous value.
- While locked=0, outputs are forced to dout=0, de=0, c0=0, c1=0.
- State machine states: SEARCH, SLIP, LOCKED.
- SEARCH:
  - run_cnt increments on each token and clears on any non-token; it saturates at TOKEN_RUN.
  - timer increments every cycle.
  - When run_cnt reaches TOKEN_RUN → LOCKED, locked=1 on the next edge, timer cleared.
  - When timer reaches TIMEOUT-1 → SLIP. Lock takes priority if both occur on the same cycle.
- SLIP:
  - slip_cnt = (slip_cnt==9) ? 0 : slip_cnt+1, applied on entry.
  - Hold for SETTLE cycles with run_cnt and timer cleared and tokens ignored, then → SEARCH.
- LOCKED:
  - timer clears on every token and increments otherwise.
  - When timer reaches TIMEOUT-1 → locked=0 on the next edge, then → SLIP.
  - A token arriving in the same cycle the timer would expire wins: timer clears and lock is kept.
- slip_cnt changes only in SLIP; it wraps 9→0 and values 10..15 never occur.

Test Plan:
- Reset: hold rstin=1 for 3 cycles with random raw_word → all outputs 0, slip_cnt=0, locked=0.
- Aligned lock: 20 words of 10'h354, then 10'h100 → locked=1 after the 8th token plus 2 cycles; slip_cnt=0; 10'h100 produces dout=8'h00, de=1 two cycles later.
- Offset lock (TIMEOUT=64): continuous serial stream of 10'h354 tokens and data, with symbol boundaries at raw bit 3 → slip_cnt steps 1,2,3; locked=1 with slip_cnt=3; no false lock at offsets 0..2.
- Decode values while locked: sym 10'h2FF → dout=8'hFE, de=1. sym 10'h0AB → de=0, c0=1, c1=0. sym 10'h2AB → c0=1, c1=1.
- Loss of lock (TIMEOUT=64): after lock, send 64 consecutive data words → locked falls to 0, slip_cnt increments by 1 (9→0 wrap checked separately), outputs forced to 0.
- Reset mid-lock: assert rstin for 1 cycle while locked with slip_cnt=3 → next cycle locked=0, slip_cnt=0, state SEARCH.
